interval_timer: RTL and testbench

INTERVAL_TIMER -- requirements
Module: interval_timer

---
 rtl/interval_timer.sv | 124 ++++++++++++
 tb/tb_interval_timer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interval_timer.sv
`default_nettype none
// ============================================================================
//  Module   : interval_timer
//  Function : Fetches an interval length from an external parameter store and
//             counts it down in ticks of TICK_DIV clocks, pulsing 'expired'.
//             Optional freeze input enabled by INTERVAL_TIMER_HOLD_EN.
//  Revision : 1.0  initial release
// ============================================================================
module interval_timer #(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       Reset_Sync,
    input  logic       Start_Timer,
    input  logic [1:0] Interval_sel,
    input  logic [3:0] value,
`ifdef INTERVAL_TIMER_HOLD_EN
    input  logic       Hold,
`endif
    output logic [1:0] interval,
    output logic       expired,
    output logic       busy,
    output logic [3:0] remaining
);

    localparam int unsigned c_DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH1 = 3'd1,
        S_FETCH2 = 3'd2,
        S_COUNT  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         interval_q, interval_d;
    logic [3:0]         remaining_q, remaining_d;
    logic [c_DIV_W-1:0] divider_q, divider_d;
    logic               expired_q, expired_d;
    logic               w_hold;

`ifdef INTERVAL_TIMER_HOLD_EN
    assign w_hold = Hold;
`else
    assign w_hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (Reset_Sync) begin
            state_q     <= S_IDLE;
            interval_q  <= 2'b00;
            remaining_q <= 4'd0;
            divider_q   <= '0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            interval_q  <= interval_d;
            remaining_q <= remaining_d;
            divider_q   <= divider_d;
            expired_q   <= expired_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        interval_d  = interval_q;
        remaining_d = remaining_q;
        divider_d   = divider_q;
        expired_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start_Timer) begin
                    interval_d = Interval_sel;
                    state_d    = S_FETCH1;
                end
            end
            // The store answers one clock after 'interval' moves, so FETCH1 just waits.
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: begin
                remaining_d = value;
                divider_d   = '0;
                state_d     = (value != 4'd0) ? S_COUNT : S_DONE;
            end
            S_COUNT: begin
                if (Start_Timer) begin
                    interval_d = Interval_sel;
                    state_d    = S_FETCH1;
                end else if (!w_hold) begin
                    if (divider_q == c_DIV_MAX) begin
                        divider_d = '0;
                        if (remaining_q != 4'd0) begin
                            remaining_d = remaining_q - 4'd1;
                        end
                        if (remaining_q == 4'd1) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        divider_d = divider_q + c_DIV_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (Start_Timer) begin
                    interval_d = Interval_sel;
                    state_d    = S_FETCH1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Registering the DONE entry makes 'expired' coincide with the DONE cycle.
        expired_d = (state_d == S_DONE);
    end

    assign interval  = interval_q;
    assign expired   = expired_q;
    assign remaining = remaining_q;
    assign busy      = (state_q == S_FETCH1) || (state_q == S_FETCH2) || (state_q == S_COUNT);

endmodule
`default_nettype wire

// File: tb/tb_interval_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_interval_timer
//  Function : Directed self-checking bench for interval_timer (TICK_DIV=4)
//             with a registered one-cycle-latency parameter store model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_interval_timer;

    logic       clk;
    logic       Reset_Sync;
    logic       Start_Timer;
    logic [1:0] Interval_sel;
    logic [3:0] value;
    logic [1:0] interval;
    logic       expired;
    logic       busy;
    logic [3:0] remaining;
`ifdef INTERVAL_TIMER_HOLD_EN
    logic       Hold;
`endif

    logic [3:0] store_mem [4];
    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int dbl_cnt = 0;
    int e_base;
    int d_base;
    logic prev_exp = 1'b0;

    interval_timer #(.TICK_DIV(4)) dut (
        .clk          (clk),
        .Reset_Sync   (Reset_Sync),
        .Start_Timer  (Start_Timer),
        .Interval_sel (Interval_sel),
        .value        (value),
`ifdef INTERVAL_TIMER_HOLD_EN
        .Hold         (Hold),
`endif
        .interval     (interval),
        .expired      (expired),
        .busy         (busy),
        .remaining    (remaining)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) value <= store_mem[interval];

    // Pulse counter sampled mid-cycle; also flags any two-cycle-wide pulse.
    always @(negedge clk) begin
        if (expired === 1'b1) begin
            exp_cnt++;
            if (prev_exp) dbl_cnt++;
        end
        prev_exp = (expired === 1'b1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        store_mem[0] = 4'd5;
        store_mem[1] = 4'd3;
        store_mem[2] = 4'd7;
        store_mem[3] = 4'd0;
        Reset_Sync   = 1'b1;
        Start_Timer  = 1'b1;
        Interval_sel = 2'b01;
`ifdef INTERVAL_TIMER_HOLD_EN
        Hold         = 1'b0;
`endif
        // Reset with a simultaneous start request that must be dropped
        step(3);
        check("rst_interval", interval, 2'b00);
        check("rst_expired", expired, 1'b0);
        check("rst_remaining", remaining, 4'd0);
        check("rst_busy", busy, 1'b0);
        Reset_Sync  = 1'b0;
        Start_Timer = 1'b0;
        step(2);
        check("rst_start_dropped", busy, 1'b0);

        // Basic interval: sel=1, value=3 -> expired at E14
        e_base = exp_cnt;
        Interval_sel = 2'b01;
        Start_Timer  = 1'b1;
        step(1);
        Start_Timer  = 1'b0;
        check("t1_interval_e0", interval, 2'b01);
        check("t1_busy_e0", busy, 1'b1);
        step(2);
        check("t1_rem_e2", remaining, 4'd3);
        step(4);
        check("t1_rem_e6", remaining, 4'd2);
        step(4);
        check("t1_rem_e10", remaining, 4'd1);
        step(3);
        check("t1_exp_e13", expired, 1'b0);
        step(1);
        check("t1_rem_e14", remaining, 4'd0);
        check("t1_exp_e14", expired, 1'b1);
        check("t1_busy_e14", busy, 1'b0);
        step(1);
        check("t1_exp_e15", expired, 1'b0);
        check("t1_pulse_count", exp_cnt - e_base, 1);

        // Zero-length interval -> DONE straight from FETCH2
        Interval_sel = 2'b11;
        Start_Timer  = 1'b1;
        step(1);
        Start_Timer  = 1'b0;
        step(1);
        check("t2_exp_e1", expired, 1'b0);
        step(1);
        check("t2_exp_e2", expired, 1'b1);
        check("t2_rem_e2", remaining, 4'd0);
        check("t2_busy_e2", busy, 1'b0);
        step(1);
        check("t2_exp_e3", expired, 1'b0);

        // Restart mid-COUNT aborts without a pulse
        e_base = exp_cnt;
        Interval_sel = 2'b00;
        Start_Timer  = 1'b1;
        step(1);
        Start_Timer  = 1'b0;
        step(7);
        Interval_sel = 2'b10;
        Start_Timer  = 1'b1;
        step(1);
        Start_Timer  = 1'b0;
        check("t3_interval_e8", interval, 2'b10);
        check("t3_rem_hold_e8", remaining, 4'd4);
        check("t3_busy_e8", busy, 1'b1);
        step(2);
        check("t3_rem_e10", remaining, 4'd7);
        check("t3_no_pulse", exp_cnt - e_base, 0);
        step(27);
        check("t3_exp_e37", expired, 1'b0);
        step(1);
        check("t3_exp_e38", expired, 1'b1);
        step(2);

        // Start held with value=0: pulse every 3 cycles, never back-to-back
        e_base = exp_cnt;
        d_base = dbl_cnt;
        Interval_sel = 2'b11;
        Start_Timer  = 1'b1;
        step(12);
        check("t4_exp_e11", expired, 1'b1);
        check("t4_pulses_e11", exp_cnt - e_base, 3);
        Start_Timer = 1'b0;
        step(2);
        check("t4_pulses_total", exp_cnt - e_base, 4);
        check("t4_no_double", dbl_cnt - d_base, 0);
        check("t4_idle", busy, 1'b0);

        // DONE-accept back-to-back with value=1: next pulse 7 edges later
        store_mem[1] = 4'd1;
        Interval_sel = 2'b01;
        Start_Timer  = 1'b1;
        step(1);
        Start_Timer  = 1'b0;
        step(5);
        check("t5_exp_e5", expired, 1'b0);
        step(1);
        check("t5_exp_e6", expired, 1'b1);
        Start_Timer = 1'b1;
        step(1);
        Start_Timer = 1'b0;
        check("t5_busy_e7", busy, 1'b1);
        check("t5_exp_e7", expired, 1'b0);
        step(5);
        check("t5_exp_e12", expired, 1'b0);
        step(1);
        check("t5_exp_e13", expired, 1'b1);
        step(2);

        // Reset mid-COUNT of a value=4 interval
        store_mem[2] = 4'd4;
        Interval_sel = 2'b10;
        Start_Timer  = 1'b1;
        step(1);
        Start_Timer  = 1'b0;
        step(6);
        check("t6_rem_e6", remaining, 4'd3);
        Reset_Sync = 1'b1;
        step(1);
        Reset_Sync = 1'b0;
        check("t6_busy_e7", busy, 1'b0);
        check("t6_rem_e7", remaining, 4'd0);
        check("t6_interval_e7", interval, 2'b00);
        check("t6_exp_e7", expired, 1'b0);
        e_base = exp_cnt;
        step(20);
        check("t6_no_pulse", exp_cnt - e_base, 0);
        check("t6_idle", busy, 1'b0);

`ifdef INTERVAL_TIMER_HOLD_EN
        // Hold for 10 cycles from E4..E13 pushes expiry from E10 to E20
        store_mem[1] = 4'd2;
        Interval_sel = 2'b01;
        Start_Timer  = 1'b1;
        step(1);
        Start_Timer  = 1'b0;
        step(3);
        check("th_rem_e3", remaining, 4'd2);
        Hold = 1'b1;
        step(10);
        Hold = 1'b0;
        check("th_rem_e13", remaining, 4'd2);
        check("th_busy_e13", busy, 1'b1);
        step(6);
        check("th_exp_e19", expired, 1'b0);
        step(1);
        check("th_exp_e20", expired, 1'b1);
        step(2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
